// File: rtl/timer_pkg.sv
// Shared constants and prescale-select encodings for the APB timer counting engine.
package timer_pkg;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_PRE_W = 4;

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;

  // Low-bit mask of the prescaler that must be all ones on a tick cycle.
  function automatic logic [3:0] cks_mask(input logic [1:0] cks);
    case (cks_e'(cks))
      CKS_DIV2:  cks_mask = 4'h1;
      CKS_DIV4:  cks_mask = 4'h3;
      CKS_DIV8:  cks_mask = 4'h7;
      CKS_DIV16: cks_mask = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides pclk by 2^(cks+1); restarts whenever counting is paused, loaded or re-scaled.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       en,
  input  logic       load,
  input  logic [1:0] cks,
  output logic       tick
);

  logic [PRE_W-1:0] div_cnt;
  logic [PRE_W-1:0] mask;
  logic [1:0]       cks_q;
  logic             restart;

  assign restart = !en || load || (cks != cks_q);
  assign mask    = PRE_W'(cks_mask(cks));
  assign tick    = !restart && ((div_cnt & mask) == mask);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      div_cnt <= '0;
      cks_q   <= '0;
    end else begin
      cks_q <= cks;
      if (restart) div_cnt <= '0;
      else         div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_counter_core.sv
// Counting engine of the APB timer: up/down counter advanced by the prescaler tick,
// with single-cycle overflow/underflow trigger pulses.
module timer_counter_core
  import timer_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             en,
  input  logic             load,
  input  logic             updown,
  input  logic [1:0]       cks,
  input  logic [CNT_W-1:0] tdr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf_trig,
  output logic             udf_trig
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic tick;

  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .pclk   (pclk),
    .preset (preset),
    .en     (en),
    .load   (load),
    .cks    (cks),
    .tick   (tick)
  );

  // Down-count from 0 wraps to MAX through ordinary modular subtraction.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt      <= '0;
      ovf_trig <= 1'b0;
      udf_trig <= 1'b0;
    end else begin
      ovf_trig <= 1'b0;
      udf_trig <= 1'b0;
      if (load) begin
        cnt <= tdr;
      end else if (tick && !updown) begin
        cnt      <= cnt + 1'b1;
        ovf_trig <= (cnt == MAX);
      end else if (tick) begin
        cnt      <= cnt - 1'b1;
        udf_trig <= (cnt == '0);
      end
    end
  end

endmodule

// File: tb/tb_timer_counter_core.sv
// Bench for timer_counter_core: directed scenarios plus randomized traffic against a
// behavioural model that counts enabled cycles since the last prescaler restart.
module tb_timer_counter_core;

  localparam longint MAXV = 64'hFFFF_FFFF;

  logic        pclk;
  logic        preset;
  logic        en;
  logic        load;
  logic        updown;
  logic [1:0]  cks;
  logic [31:0] tdr;
  logic [31:0] cnt;
  logic        ovf_trig;
  logic        udf_trig;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 0;

  timer_counter_core #(.CNT_W(32), .PRE_W(4)) dut (
    .pclk     (pclk),
    .preset   (preset),
    .en       (en),
    .load     (load),
    .updown   (updown),
    .cks      (cks),
    .tdr      (tdr),
    .cnt      (cnt),
    .ovf_trig (ovf_trig),
    .udf_trig (udf_trig)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // behavioural model
  longint m_cnt;
  bit     m_ovf, m_udf, m_tick;
  int     m_run;
  logic [1:0] m_cks_prev;

  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      m_cnt = 0; m_ovf = 0; m_udf = 0; m_run = 0; m_cks_prev = 2'b00;
    end else begin
      m_tick = 0; m_ovf = 0; m_udf = 0;
      if (!en || load || cks != m_cks_prev) begin
        m_run = 0;
      end else begin
        m_run++;
        m_tick = (m_run % (2 << cks)) == 0;
      end
      m_cks_prev = cks;
      if (load) begin
        m_cnt = longint'(tdr);
      end else if (m_tick && !updown) begin
        m_ovf = (m_cnt == MAXV);
        m_cnt = (m_cnt + 1) % (MAXV + 1);
      end else if (m_tick) begin
        m_udf = (m_cnt == 0);
        m_cnt = (m_cnt + MAXV) % (MAXV + 1);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every cycle against the model
  always @(negedge pclk) begin
    if (chk_en) begin
      check("model_cnt", cnt, m_cnt[31:0]);
      check("model_ovf", {31'd0, ovf_trig}, {31'd0, m_ovf});
      check("model_udf", {31'd0, udf_trig}, {31'd0, m_udf});
      check("trig_exclusive", {31'd0, ovf_trig & udf_trig}, 32'd0);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic do_load(input logic [31:0] v);
    load = 1'b1; tdr = v;
    step(1);
    load = 1'b0;
  endtask

  function automatic logic [31:0] pick_tdr();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'hFFFF_FFFE;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    preset = 1'b1; en = 1'b0; load = 1'b0; updown = 1'b0; cks = 2'b00; tdr = '0;
    step(2);
    preset = 1'b0;
    chk_en = 1'b1;
    check("reset_cnt", cnt, 32'h0);
    check("reset_ovf", {31'd0, ovf_trig}, 32'd0);
    check("reset_udf", {31'd0, udf_trig}, 32'd0);

    // basic up count at /2
    do_load(32'h10);
    en = 1'b1;
    check("load_val", cnt, 32'h10);
    step(2); check("up_first", cnt, 32'h11);
    step(2); check("up_second", cnt, 32'h12);

    // overflow wrap
    do_load(32'hFFFF_FFFE);
    step(2); check("ovf_pre_cnt", cnt, 32'hFFFF_FFFF);
    check("ovf_pre_trig", {31'd0, ovf_trig}, 32'd0);
    step(2); check("ovf_wrap_cnt", cnt, 32'h0);
    check("ovf_pulse", {31'd0, ovf_trig}, 32'd1);
    check("ovf_no_udf", {31'd0, udf_trig}, 32'd0);
    step(1); check("ovf_pulse_end", {31'd0, ovf_trig}, 32'd0);

    // underflow at /16
    updown = 1'b1; cks = 2'b11;
    do_load(32'h1);
    step(16); check("dn_zero", cnt, 32'h0);
    check("dn_zero_no_udf", {31'd0, udf_trig}, 32'd0);
    step(16); check("udf_wrap_cnt", cnt, 32'hFFFF_FFFF);
    check("udf_pulse", {31'd0, udf_trig}, 32'd1);
    step(1); check("udf_pulse_end", {31'd0, udf_trig}, 32'd0);

    // cks change mid-period
    updown = 1'b0; cks = 2'b00;
    do_load(32'h100);
    step(3); check("cks_pre", cnt, 32'h101);
    cks = 2'b10;
    step(1); check("cks_change_no_tick", cnt, 32'h101);
    step(7); check("cks_hold7", cnt, 32'h101);
    step(1); check("cks_tick8", cnt, 32'h102);

    // en dropped mid-period
    step(3);
    en = 1'b0;
    step(5); check("en_frozen", cnt, 32'h102);
    en = 1'b1;
    step(7); check("en_full_period_hold", cnt, 32'h102);
    step(1); check("en_full_period_tick", cnt, 32'h103);

    // load wins on a tick edge at MAX
    cks = 2'b00;
    do_load(32'hFFFF_FFFF);
    step(1);
    do_load(32'h55);
    check("load_on_tick_cnt", cnt, 32'h55);
    check("load_on_tick_no_ovf", {31'd0, ovf_trig}, 32'd0);

    // asynchronous reset mid-count
    step(5); check("pre_reset_cnt", cnt, 32'h57);
    #2 preset = 1'b1;
    #1;
    check("async_rst_cnt", cnt, 32'h0);
    check("async_rst_ovf", {31'd0, ovf_trig}, 32'd0);
    check("async_rst_udf", {31'd0, udf_trig}, 32'd0);
    step(1);
    preset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 99) < 4);
      if (load) tdr = pick_tdr();
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) updown = ~updown;
      if ($urandom_range(0, 59) == 0) cks = 2'($urandom_range(0, 3));
      step(1);
    end

    load = 1'b0; en = 1'b0;
    step(2);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
